// File: rtl/decode_queue.sv
// decode_queue: RV32 decoder that writes fully decoded bundles into a DEPTH-entry FIFO.
// Build option: define RV_MEXT_EN to decode the M extension; without it those encodings are illegal.
module decode_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_instr,
  input  logic [XLEN-1:0]         in_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_pc,
  output logic [XLEN-1:0]         out_imm,
  output logic [31:0]             out_instr,
  output logic [4:0]              out_rd,
  output logic [4:0]              out_rs1,
  output logic [4:0]              out_rs2,
  output logic [4:0]              out_alu_op,
  output logic [1:0]              out_alu_in1_src,
  output logic                    out_alusrc,
  output logic                    out_mem_read,
  output logic                    out_mem_write,
  output logic                    out_reg_write,
  output logic                    out_mem_to_reg,
  output logic [3:0]              out_kind,
  output logic                    out_illegal,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW:0] DEPTH_C = CW'(DEPTH);

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_SLL  = 5'd2;
  localparam logic [4:0] ALU_SLT  = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_OR   = 5'd8;
  localparam logic [4:0] ALU_AND  = 5'd9;
`ifdef RV_MEXT_EN
  // MUL..REMU occupy ALU_MUL + funct3
  localparam logic [4:0] ALU_MUL  = 5'd10;
`endif

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_ATOMIC = 7'b0101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [3:0] K_ALU    = 4'd0;
  localparam logic [3:0] K_LOAD   = 4'd1;
  localparam logic [3:0] K_STORE  = 4'd2;
  localparam logic [3:0] K_BRANCH = 4'd3;
  localparam logic [3:0] K_JAL    = 4'd4;
  localparam logic [3:0] K_JALR   = 4'd5;
  localparam logic [3:0] K_LUI    = 4'd6;
  localparam logic [3:0] K_AUIPC  = 4'd7;
  localparam logic [3:0] K_CSR    = 4'd8;
  localparam logic [3:0] K_ECALL  = 4'd9;
  localparam logic [3:0] K_EBREAK = 4'd10;
  localparam logic [3:0] K_MRET   = 4'd11;
  localparam logic [3:0] K_SRET   = 4'd12;
  localparam logic [3:0] K_SFENCE = 4'd13;
  localparam logic [3:0] K_ATOMIC = 4'd14;
  localparam logic [3:0] K_FENCE  = 4'd15;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [31:0]     instr;
    logic [4:0]      alu_op;
    logic [1:0]      alu_in1_src;
    logic            alusrc;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic            mem_to_reg;
    logic [3:0]      kind;
    logic            illegal;
  } entry_t;

  function automatic logic [4:0] alu_map(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_map = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_map = ALU_SLL;
      3'b010:  alu_map = ALU_SLT;
      3'b011:  alu_map = ALU_SLTU;
      3'b100:  alu_map = ALU_XOR;
      3'b101:  alu_map = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_map = ALU_OR;
      default: alu_map = ALU_AND;
    endcase
  endfunction

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_x;
  logic [4:0]      d_alu_op;
  logic [1:0]      d_in1;
  logic            d_alusrc, d_mr, d_mw, d_rw, d_m2r, d_bad;
  logic [3:0]      d_kind;

  always_comb begin
    imm32    = '0;
    d_alu_op = ALU_ADD;
    d_in1    = 2'b00;
    d_alusrc = 1'b0;
    d_mr     = 1'b0;
    d_mw     = 1'b0;
    d_rw     = 1'b0;
    d_m2r    = 1'b0;
    d_kind   = K_ALU;
    d_bad    = 1'b0;
    case (opcode)
      OPC_OP: begin
        d_rw = 1'b1;
        if (funct7 == 7'b0000000) begin
          d_alu_op = alu_map(funct3, 1'b0);
        end else if (funct7 == 7'b0100000) begin
          d_alu_op = alu_map(funct3, 1'b1);
          if (funct3 != 3'b000 && funct3 != 3'b101) d_bad = 1'b1;
`ifdef RV_MEXT_EN
        end else if (funct7 == 7'b0000001) begin
          d_alu_op = ALU_MUL + {2'b00, funct3};
`endif
        end else begin
          d_bad = 1'b1;
        end
      end
      OPC_OPIMM: begin
        d_rw     = 1'b1;
        d_alusrc = 1'b1;
        imm32    = {{20{in_instr[31]}}, in_instr[31:20]};
        // only the shift-right form borrows instr[30] as the arithmetic select
        d_alu_op = alu_map(funct3, (funct3 == 3'b101) && in_instr[30]);
        if (funct3 == 3'b001 && funct7 != 7'b0000000) d_bad = 1'b1;
        if (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000) d_bad = 1'b1;
      end
      OPC_LOAD: begin
        d_kind   = K_LOAD;
        d_alusrc = 1'b1;
        d_mr     = 1'b1;
        d_m2r    = 1'b1;
        d_rw     = 1'b1;
        imm32    = {{20{in_instr[31]}}, in_instr[31:20]};
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) d_bad = 1'b1;
      end
      OPC_STORE: begin
        d_kind   = K_STORE;
        d_alusrc = 1'b1;
        d_mw     = 1'b1;
        imm32    = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        if (funct3 > 3'b010) d_bad = 1'b1;
      end
      OPC_BRANCH: begin
        d_kind   = K_BRANCH;
        d_alu_op = ALU_SUB;
        imm32    = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                    in_instr[11:8], 1'b0};
        if (funct3 == 3'b010 || funct3 == 3'b011) d_bad = 1'b1;
      end
      OPC_JAL: begin
        d_kind = K_JAL;
        d_in1  = 2'b11;
        d_rw   = 1'b1;
        imm32  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                  in_instr[30:21], 1'b0};
      end
      OPC_JALR: begin
        d_kind   = K_JALR;
        d_alusrc = 1'b1;
        d_rw     = 1'b1;
        imm32    = {{20{in_instr[31]}}, in_instr[31:20]};
        if (funct3 != 3'b000) d_bad = 1'b1;
      end
      OPC_LUI: begin
        d_kind   = K_LUI;
        d_in1    = 2'b10;
        d_alusrc = 1'b1;
        d_rw     = 1'b1;
        imm32    = {in_instr[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        d_kind   = K_AUIPC;
        d_in1    = 2'b01;
        d_alusrc = 1'b1;
        d_rw     = 1'b1;
        imm32    = {in_instr[31:12], 12'b0};
      end
      OPC_SYSTEM: begin
        if (funct3 != 3'b000) begin
          d_kind   = K_CSR;
          d_rw     = 1'b1;
          d_alusrc = funct3[2];
          if (funct3[2]) imm32 = {27'b0, in_instr[19:15]};
        end else if (in_instr[31:20] == 12'h001) begin
          d_kind = K_EBREAK;
        end else if (in_instr[31:20] == 12'h302) begin
          d_kind = K_MRET;
        end else if (in_instr[31:20] == 12'h102) begin
          d_kind = K_SRET;
        end else if (funct7 == 7'b0001001) begin
          d_kind = K_SFENCE;
        end else begin
          d_kind = K_ECALL;
        end
      end
      OPC_ATOMIC: begin
        d_kind   = K_ATOMIC;
        d_alusrc = 1'b1;
        d_mr     = 1'b1;
        d_m2r    = 1'b1;
        d_rw     = 1'b1;
        if (funct3 != 3'b010) d_bad = 1'b1;
      end
      OPC_FENCE: d_kind = K_FENCE;
      default:   d_bad  = 1'b1;
    endcase
  end

  assign imm_x = XLEN'($signed(imm32));

  entry_t new_entry;

  always_comb begin
    new_entry             = '0;
    new_entry.pc          = in_pc;
    new_entry.imm         = imm_x;
    new_entry.instr       = in_instr;
    new_entry.alu_op      = d_alu_op;
    new_entry.alu_in1_src = d_in1;
    new_entry.alusrc      = d_alusrc;
    new_entry.kind        = d_kind;
    new_entry.illegal     = d_bad;
    // illegal entries must not cause architectural side effects before the trap
    new_entry.mem_read    = d_mr  & ~d_bad;
    new_entry.mem_write   = d_mw  & ~d_bad;
    new_entry.reg_write   = d_rw  & ~d_bad;
    new_entry.mem_to_reg  = d_m2r & ~d_bad;
  end

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            push, pop;
  entry_t          head;

  assign in_ready  = (count < DEPTH_C);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= new_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head            = mem[rd_ptr];
  assign out_pc          = head.pc;
  assign out_imm         = head.imm;
  assign out_instr       = head.instr;
  assign out_rd          = head.instr[11:7];
  assign out_rs1         = head.instr[19:15];
  assign out_rs2         = head.instr[24:20];
  assign out_alu_op      = head.alu_op;
  assign out_alu_in1_src = head.alu_in1_src;
  assign out_alusrc      = head.alusrc;
  assign out_mem_read    = head.mem_read;
  assign out_mem_write   = head.mem_write;
  assign out_reg_write   = head.reg_write;
  assign out_mem_to_reg  = head.mem_to_reg;
  assign out_kind        = head.kind;
  assign out_illegal     = head.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: directed and random stimulus against a queue-based reference decoder.
module tb_decode_queue;
  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  localparam logic [4:0] A_ADD = 5'd0, A_SUB = 5'd1, A_SLL = 5'd2, A_SLT = 5'd3, A_SLTU = 5'd4;
  localparam logic [4:0] A_XOR = 5'd5, A_SRL = 5'd6, A_SRA = 5'd7, A_OR = 5'd8, A_AND = 5'd9;
  localparam logic [4:0] A_MUL = 5'd10;

  logic clk = 1'b0;
  logic rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, out_instr;
  logic [XLEN-1:0] in_pc, out_pc, out_imm;
  logic [4:0] out_rd, out_rs1, out_rs2, out_alu_op;
  logic [1:0] out_alu_in1_src;
  logic out_alusrc, out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg, out_illegal;
  logic [3:0] out_kind;
  logic [$clog2(DEPTH):0] count;

  decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_imm(out_imm), .out_instr(out_instr), .out_rd(out_rd),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_alu_op(out_alu_op),
    .out_alu_in1_src(out_alu_in1_src), .out_alusrc(out_alusrc), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_reg_write(out_reg_write),
    .out_mem_to_reg(out_mem_to_reg), .out_kind(out_kind), .out_illegal(out_illegal),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, instr, imm;
    logic [4:0]  alu_op;
    logic [1:0]  in1;
    logic        alusrc, mr, mw, rw, m2r, ill;
    logic [3:0]  kind;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] ref_alu(input logic [2:0] f3, input logic alt);
    logic [4:0] tbl [8];
    tbl = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};
    if (alt && f3 == 3'd0) return A_SUB;
    if (alt && f3 == 3'd5) return A_SRA;
    return tbl[f3];
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] pc);
    exp_t e;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [12:0] b;
    logic [20:0] j;
    int v;
    f7 = i[31:25];
    f3 = i[14:12];
    e = '{pc: pc, instr: i, imm: 32'h0, alu_op: A_ADD, in1: 2'b00, alusrc: 1'b0, mr: 1'b0,
          mw: 1'b0, rw: 1'b0, m2r: 1'b0, ill: 1'b0, kind: 4'd0};
    case (i[6:0])
      7'h33: begin
        e.rw = 1'b1;
        if (f7 == 7'h00) e.alu_op = ref_alu(f3, 1'b0);
        else if (f7 == 7'h20) begin
          e.alu_op = ref_alu(f3, 1'b1);
          e.ill = !(f3 == 3'd0 || f3 == 3'd5);
        end
`ifdef RV_MEXT_EN
        else if (f7 == 7'h01) e.alu_op = A_MUL + {2'b00, f3};
`endif
        else e.ill = 1'b1;
      end
      7'h13: begin
        e.rw = 1'b1; e.alusrc = 1'b1;
        v = int'(i) / (1 << 20);
        if (i[31] && (i[19:0] != 20'h0)) v = v - 1;
        e.imm = 32'(v);
        e.alu_op = ref_alu(f3, f3 == 3'd5 && i[30]);
        if (f3 == 3'd1 && f7 != 7'h00) e.ill = 1'b1;
        if (f3 == 3'd5 && !(f7 == 7'h00 || f7 == 7'h20)) e.ill = 1'b1;
      end
      7'h03: begin
        e.kind = 4'd1; e.alusrc = 1'b1; e.mr = 1'b1; e.m2r = 1'b1; e.rw = 1'b1;
        e.imm = 32'(i[31:20]) - (i[31] ? 32'd4096 : 32'd0);
        e.ill = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      end
      7'h23: begin
        e.kind = 4'd2; e.alusrc = 1'b1; e.mw = 1'b1;
        e.imm = 32'({i[31:25], i[11:7]}) - (i[31] ? 32'd4096 : 32'd0);
        e.ill = (f3 > 3'd2);
      end
      7'h63: begin
        e.kind = 4'd3; e.alu_op = A_SUB;
        b = {i[31], i[7], i[30:25], i[11:8], 1'b0};
        e.imm = 32'(b) - (b[12] ? 32'd8192 : 32'd0);
        e.ill = (f3 == 3'd2 || f3 == 3'd3);
      end
      7'h6F: begin
        e.kind = 4'd4; e.in1 = 2'b11; e.rw = 1'b1;
        j = {i[31], i[19:12], i[20], i[30:21], 1'b0};
        e.imm = 32'(j) - (j[20] ? 32'h0020_0000 : 32'd0);
      end
      7'h67: begin
        e.kind = 4'd5; e.alusrc = 1'b1; e.rw = 1'b1;
        e.imm = 32'(i[31:20]) - (i[31] ? 32'd4096 : 32'd0);
        e.ill = (f3 != 3'd0);
      end
      7'h37: begin
        e.kind = 4'd6; e.in1 = 2'b10; e.alusrc = 1'b1; e.rw = 1'b1;
        e.imm = i & 32'hFFFF_F000;
      end
      7'h17: begin
        e.kind = 4'd7; e.in1 = 2'b01; e.alusrc = 1'b1; e.rw = 1'b1;
        e.imm = i & 32'hFFFF_F000;
      end
      7'h73: begin
        if (f3 != 3'd0) begin
          e.kind = 4'd8; e.rw = 1'b1; e.alusrc = f3[2];
          e.imm = f3[2] ? 32'(i[19:15]) : 32'h0;
        end else if (i == 32'h0010_0073) e.kind = 4'd10;
        else if (i == 32'h3020_0073) e.kind = 4'd11;
        else if (i == 32'h1020_0073) e.kind = 4'd12;
        else if (f7 == 7'h09) e.kind = 4'd13;
        else e.kind = 4'd9;
      end
      7'h2F: begin
        e.kind = 4'd14; e.alusrc = 1'b1; e.mr = 1'b1; e.m2r = 1'b1; e.rw = 1'b1;
        e.ill = (f3 != 3'd2);
      end
      7'h0F: e.kind = 4'd15;
      default: e.ill = 1'b1;
    endcase
    if (e.ill) begin
      e.rw = 1'b0; e.mr = 1'b0; e.mw = 1'b0; e.m2r = 1'b0;
    end
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 14))
      0: begin
        r[6:0] = 7'h33;
        case ($urandom_range(0, 3))
          0: r[31:25] = 7'h00;
          1: r[31:25] = 7'h20;
          2: r[31:25] = 7'h01;
          default: ;
        endcase
      end
      1: begin
        r[6:0] = 7'h13;
        if ($urandom_range(0, 1) == 1) r[31:25] = r[30] ? 7'h20 : 7'h00;
      end
      2: r[6:0] = 7'h03;
      3: r[6:0] = 7'h23;
      4: r[6:0] = 7'h63;
      5: r[6:0] = 7'h6F;
      6: begin
        r[6:0] = 7'h67;
        if ($urandom_range(0, 3) != 0) r[14:12] = 3'b000;
      end
      7: r[6:0] = 7'h37;
      8: r[6:0] = 7'h17;
      9: begin
        r[6:0] = 7'h73;
        if (r[14:12] == 3'b000) r[14:12] = 3'b010;
      end
      10: case ($urandom_range(0, 4))
        0: r = 32'h0000_0073;
        1: r = 32'h0010_0073;
        2: r = 32'h3020_0073;
        3: r = 32'h1020_0073;
        default: begin r[31:25] = 7'h09; r[14:0] = 15'h0073; end
      endcase
      11: begin
        r[6:0] = 7'h2F;
        if ($urandom_range(0, 3) != 0) r[14:12] = 3'b010;
      end
      12: r[6:0] = 7'h0F;
      13: if (r[6:0] == 7'h73) r[2] = 1'b1;
      default: r[1:0] = 2'($urandom_range(0, 2));
    endcase
    return r;
  endfunction

  task automatic check_state();
    exp_t e;
    check("count", 64'(count), 64'(q.size()));
    check("out_valid", 64'(out_valid), 64'(q.size() != 0));
    check("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
    if (q.size() != 0) begin
      e = q[0];
      check("pc", 64'(out_pc), 64'(e.pc));
      check("instr", 64'(out_instr), 64'(e.instr));
      check("rd", 64'(out_rd), 64'(e.instr[11:7]));
      check("rs1", 64'(out_rs1), 64'(e.instr[19:15]));
      check("rs2", 64'(out_rs2), 64'(e.instr[24:20]));
      check("illegal", 64'(out_illegal), 64'(e.ill));
      check("reg_write", 64'(out_reg_write), 64'(e.rw));
      check("mem_read", 64'(out_mem_read), 64'(e.mr));
      check("mem_write", 64'(out_mem_write), 64'(e.mw));
      check("mem_to_reg", 64'(out_mem_to_reg), 64'(e.m2r));
      if (!e.ill) begin
        check("imm", 64'(out_imm), 64'(e.imm));
        check("alu_op", 64'(out_alu_op), 64'(e.alu_op));
        check("alu_in1_src", 64'(out_alu_in1_src), 64'(e.in1));
        check("alusrc", 64'(out_alusrc), 64'(e.alusrc));
        check("kind", 64'(out_kind), 64'(e.kind));
      end
    end
  endtask

  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic rdy, input logic fl);
    logic push, pop;
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = rdy; flush = fl;
    push = v && (q.size() < DEPTH) && !fl;
    pop  = (q.size() != 0) && rdy && !fl;
    if (fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(ref_decode(ins, pc));
    end
    @(posedge clk);
    @(negedge clk);
    check_state();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_pc", 64'(out_pc), 64'd0);
    check("rst_out_instr", 64'(out_instr), 64'd0);
    check("rst_out_imm", 64'(out_imm), 64'd0);
    check("rst_reg_write", 64'(out_reg_write), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // ADDI x5,x1,-3 held at the head
    step(1'b1, 32'hFFD0_8293, 32'h100, 1'b0, 1'b0);
    check("addi_valid", 64'(out_valid), 64'd1);
    check("addi_imm", 64'(out_imm), 64'hFFFF_FFFD);
    check("addi_alu_op", 64'(out_alu_op), 64'(A_ADD));
    check("addi_alusrc", 64'(out_alusrc), 64'd1);
    check("addi_rd", 64'(out_rd), 64'd5);
    check("addi_count", 64'(count), 64'd1);

    // fill, hold a third, then drain across the pointer wrap
    step(1'b1, 32'hFE00_0CE3, 32'h104, 1'b0, 1'b0);
    check("full_in_ready", 64'(in_ready), 64'd0);
    step(1'b1, 32'h0000_0000, 32'h108, 1'b0, 1'b0);
    check("held_count", 64'(count), 64'd2);
    step(1'b1, 32'h0000_0000, 32'h108, 1'b1, 1'b0);
    check("beq_imm", 64'(out_imm), 64'hFFFF_FFF8);
    check("beq_kind", 64'(out_kind), 64'd3);
    step(1'b1, 32'h0000_0000, 32'h108, 1'b1, 1'b0);
    check("zero_illegal", 64'(out_illegal), 64'd1);
    check("zero_wen", 64'({out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg}), 64'd0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("drained", 64'(out_valid), 64'd0);

    // streaming at occupancy 1
    step(1'b1, gen_instr(), 32'h200, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      step(1'b1, gen_instr(), 32'h204 + 32'(4 * k), 1'b1, 1'b0);
      check("stream_count", 64'(count), 64'd1);
    end

    // flush with a push in the same cycle
    step(1'b1, gen_instr(), 32'h300, 1'b0, 1'b0);
    check("preflush_count", 64'(count), 64'd2);
    step(1'b1, 32'h0010_0073, 32'h304, 1'b1, 1'b1);
    check("flush_count", 64'(count), 64'd0);
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_ready", 64'(in_ready), 64'd1);
    step(1'b1, 32'h0000_0073, 32'h308, 1'b0, 1'b0);
    check("postflush_pc", 64'(out_pc), 64'h308);

    // MUL x3,x1,x2
    step(1'b1, 32'h0220_81B3, 32'h30C, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
`ifdef RV_MEXT_EN
    check("mul_alu_op", 64'(out_alu_op), 64'(A_MUL));
    check("mul_illegal", 64'(out_illegal), 64'd0);
`else
    check("mul_illegal", 64'(out_illegal), 64'd1);
`endif
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    for (int k = 0; k < 600; k++) begin
      step(1'($urandom_range(0, 3) != 0), gen_instr(), $urandom & 32'hFFFF_FFFC,
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 39) == 0));
    end

    // asynchronous reset between edges
    step(1'b1, 32'h0050_0093, 32'h400, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0013, 32'h404, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    q.delete();
    check("arst_count", 64'(count), 64'd0);
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_ready", 64'(in_ready), 64'd1);
    check("arst_pc", 64'(out_pc), 64'd0);
    check("arst_instr", 64'(out_instr), 64'd0);
    check("arst_rd", 64'(out_rd), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 32'hFFD0_8293, 32'h500, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
